fifo_vc: RTL



---
 rtl/fifo_pkg.sv | 25 ++
 rtl/fifo_vc_if.sv | 32 +++
 rtl/fifo_mem.sv | 44 ++++
 rtl/fifo_vc.sv | 106 ++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants, types and helpers for the virtual-channel TLP FIFOs.
package fifo_pkg;

   localparam int unsigned DATA_WIDTH   = 6;
   localparam int unsigned ADDR_WIDTH   = 3;
   localparam int unsigned DEPTH        = 1 << ADDR_WIDTH;
   localparam int unsigned THR_HIGH_DEF = 6;
   localparam int unsigned THR_LOW_DEF  = 2;
   localparam int unsigned NUM_VC       = 4;

   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [ADDR_WIDTH-1:0] ptr_t;
   // One extra bit so occupancy can express DEPTH itself.
   typedef logic [ADDR_WIDTH:0]   cnt_t;

   localparam cnt_t DEPTH_CNT    = cnt_t'(DEPTH);
   localparam cnt_t THR_HIGH_RST = cnt_t'(THR_HIGH_DEF);
   localparam cnt_t THR_LOW_RST  = cnt_t'(THR_LOW_DEF);

   // A watermark pair is usable only if pause and continue can never both assert.
   function automatic logic thr_cfg_ok(cnt_t high, cnt_t low);
      return (low < high) && (high <= DEPTH_CNT);
   endfunction

endpackage

// File: rtl/fifo_vc_if.sv
// Handshake/status bundle between one VC FIFO and its producer/consumer.
interface fifo_vc_if;
   import fifo_pkg::*;

   logic  init;
   cnt_t  thr_high;
   cnt_t  thr_low;
   logic  push;
   data_t data_in;
   logic  pop;
   data_t data_out;
   logic  valid_out;
   cnt_t  count;
   logic  FIFOempty;
   logic  FIFOfull;
   logic  FIFOpause;
   logic  FIFOcontinue;
   logic  FIFOerror;

   modport master (
      output init, thr_high, thr_low, push, data_in, pop,
      input  data_out, valid_out, count,
      input  FIFOempty, FIFOfull, FIFOpause, FIFOcontinue, FIFOerror
   );

   modport slave (
      input  init, thr_high, thr_low, push, data_in, pop,
      output data_out, valid_out, count,
      output FIFOempty, FIFOfull, FIFOpause, FIFOcontinue, FIFOerror
   );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port register array with synchronous write and registered read.
module fifo_mem
   import fifo_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  we,
   input  ptr_t  waddr,
   input  data_t wdata,
   input  logic  re,
   input  ptr_t  raddr,
   output data_t rdata
);

   data_t mem_q [DEPTH];
   data_t rdata_d, rdata_q;

   // Read port holds its last value when no read is requested.
   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = mem_q[raddr];
      end
   end

   // Storage array; contents are not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Read data register; a same-edge write to raddr returns the old word.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fifo_vc.sv
// Single-VC TLP FIFO: pointers, occupancy, watermark registers, sticky error, flags.
module fifo_vc
   import fifo_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   fifo_vc_if.slave   bus
);

   ptr_t wr_ptr_d, wr_ptr_q;
   ptr_t rd_ptr_d, rd_ptr_q;
   cnt_t count_d, count_q;
   cnt_t thr_high_d, thr_high_q;
   cnt_t thr_low_d, thr_low_q;
   logic err_d, err_q;
   logic valid_d, valid_q;
   logic push_ok, pop_ok;
   data_t rdata;

   // Accept decisions; a full FIFO still takes a push when a pop frees a slot this cycle.
   always_comb begin
      pop_ok  = !bus.init && bus.pop && (count_q != '0);
      push_ok = !bus.init && bus.push && ((count_q != DEPTH_CNT) || pop_ok);
   end

   // Next-state for pointers, occupancy, watermarks and the sticky error.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      thr_high_d = thr_high_q;
      thr_low_d  = thr_low_q;
      err_d      = err_q;
      valid_d    = pop_ok;

      if (bus.init) begin
         if (thr_cfg_ok(bus.thr_high, bus.thr_low)) begin
            thr_high_d = bus.thr_high;
            thr_low_d  = bus.thr_low;
         end else begin
            err_d = 1'b1;
         end
      end else begin
         if (bus.push && !push_ok) begin
            err_d = 1'b1;
         end
         if (bus.pop && !pop_ok) begin
            err_d = 1'b1;
         end
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
         end
         unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; reset wins over init, push and pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         thr_high_q <= THR_HIGH_RST;
         thr_low_q  <= THR_LOW_RST;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         thr_high_q <= thr_high_d;
         thr_low_q  <= thr_low_d;
         err_q      <= err_d;
         valid_q    <= valid_d;
      end
   end

   fifo_mem u_mem (
      .clk   (clk),
      .reset (reset),
      .we    (push_ok && !reset),
      .waddr (wr_ptr_q),
      .wdata (bus.data_in),
      .re    (pop_ok && !reset),
      .raddr (rd_ptr_q),
      .rdata (rdata)
   );

   // Flags follow the registered count, so they move the cycle after the causing edge.
   assign bus.data_out     = rdata;
   assign bus.valid_out    = valid_q;
   assign bus.count        = count_q;
   assign bus.FIFOempty    = (count_q == '0);
   assign bus.FIFOfull     = (count_q == DEPTH_CNT);
   assign bus.FIFOpause    = (count_q >= thr_high_q);
   assign bus.FIFOcontinue = (count_q <= thr_low_q);
   assign bus.FIFOerror    = err_q;

endmodule
